// File: rtl/revaluate_slice_engine.sv
// Slice-serial chi step over a 5x5xLANE_W state with pass-through mode.
// Optional iota merge via REVALUATE_ROUND_CONST_EN (adds round_const port).
module revaluate_slice_engine #(
  parameter int LANE_W           = 64,
  parameter int SLICES_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [25*LANE_W-1:0]  data_in,
`ifdef REVALUATE_ROUND_CONST_EN
  input  logic [LANE_W-1:0]     round_const,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [25*LANE_W-1:0]  data_out
);

  localparam int NUM_CELLS = 25 * LANE_W;
  localparam int N_STEPS   = LANE_W / SLICES_PER_CYCLE;
  localparam int CW        = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  if (SLICES_PER_CYCLE < 1 || (LANE_W % SLICES_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("SLICES_PER_CYCLE must divide LANE_W");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROCESS,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_CELLS-1:0]   st_q;
  logic [NUM_CELLS-1:0]   st_d;
  logic [NUM_CELLS-1:0]   out_q;
  logic                   mode_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   last;
`ifdef REVALUATE_ROUND_CONST_EN
  logic [LANE_W-1:0]      rc_q;
`endif

  assign last     = (cnt_q == CW'(N_STEPS - 1));
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = out_q;

  // Slices are independent, so the selected ones are rewritten in place.
  always_comb begin
    logic [4:0] row;
    logic       b;
    int         z;
    int         base;
    st_d = st_q;
    row  = '0;
    b    = 1'b0;
    z    = 0;
    base = 0;
    for (int s = 0; s < SLICES_PER_CYCLE; s++) begin
      z = int'(cnt_q) * SLICES_PER_CYCLE + s;
      for (int y = 0; y < 5; y++) begin
        base = LANE_W * 5 * y;
        for (int x = 0; x < 5; x++) begin
          row[x] = st_q[base + LANE_W * x + z];
        end
        for (int x = 0; x < 5; x++) begin
          if (mode_q) begin
            b = row[x];
          end else begin
            b = row[x] ^ (~row[(x + 1) % 5] & row[(x + 2) % 5]);
          end
`ifdef REVALUATE_ROUND_CONST_EN
          if (x == 0 && y == 0) begin
            b = b ^ rc_q[z];
          end
`endif
          st_d[base + LANE_W * x + z] = b;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      out_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REVALUATE_ROUND_CONST_EN
      rc_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            st_q    <= data_in;
            mode_q  <= mode;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_PROCESS;
`ifdef REVALUATE_ROUND_CONST_EN
            rc_q    <= round_const;
`endif
          end
        end
        S_PROCESS: begin
          st_q  <= st_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            // Result registered on entry so it is valid alongside done.
            out_q   <= st_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_revaluate_slice_engine.sv
// Scoreboard bench for revaluate_slice_engine (4/1 and 64/8 configs).
// Expected results pushed at issue, popped by monitors on done.
module tb_revaluate_slice_engine;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [99:0]   din;
  logic [3:0]    rc;
  logic          busy;
  logic          done;
  logic [99:0]   dout;

  logic          start2;
  logic          mode2;
  logic [1599:0] din2;
  logic [63:0]   rc2;
  logic          busy2;
  logic          done2;
  logic [1599:0] dout2;

  logic [99:0]   exp_q[$];
  logic [1599:0] exp2_q[$];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  revaluate_slice_engine #(.LANE_W(4), .SLICES_PER_CYCLE(1)) u_dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .data_in(din),
`ifdef REVALUATE_ROUND_CONST_EN
    .round_const(rc),
`endif
    .busy(busy),
    .done(done),
    .data_out(dout)
  );

  revaluate_slice_engine #(.LANE_W(64), .SLICES_PER_CYCLE(8)) u_dut64 (
    .clk(clk),
    .rst(rst),
    .start(start2),
    .mode(mode2),
    .data_in(din2),
`ifdef REVALUATE_ROUND_CONST_EN
    .round_const(rc2),
`endif
    .busy(busy2),
    .done(done2),
    .data_out(dout2)
  );

  task automatic chk(input string name, input logic [1599:0] act,
                     input logic [1599:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [1599:0] chi_ref(input logic [1599:0] a,
                                            input int w, input logic m,
                                            input logic [63:0] r);
    logic [1599:0] o;
    o = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        for (int z = 0; z < w; z++) begin
          if (m)
            o[w*(5*y+x)+z] = a[w*(5*y+x)+z];
          else
            o[w*(5*y+x)+z] = a[w*(5*y+x)+z] ^
              (~a[w*(5*y+(x+1)%5)+z] & a[w*(5*y+(x+2)%5)+z]);
`ifdef REVALUATE_ROUND_CONST_EN
          if (x == 0 && y == 0) o[z] = o[z] ^ r[z];
`endif
        end
    return o;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done4: got done=1 required no pulse");
      end else begin
        chk("data_out4", dout, exp_q.pop_front());
      end
    end
    if (done2 === 1'b1) begin
      if (exp2_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done64: got done=1 required no pulse");
      end else begin
        chk("data_out64", dout2, exp2_q.pop_front());
      end
    end
  end

  task automatic run_job(input logic [99:0] d, input logic m,
                         input logic [99:0] e);
    @(negedge clk);
    din   = d;
    mode  = m;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  logic [99:0] v_ones;
  logic [99:0] v_pat;
  logic [99:0] v_a;
  logic [99:0] v_e;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    din    = '0;
    rc     = '0;
    start2 = 1'b0;
    mode2  = 1'b0;
    din2   = '0;
    rc2    = '0;
    v_ones = '1;
    v_pat  = 100'h9_3C5A_F012_7E81_D4B6_0A5C_3E2F;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy64", busy2, 0);
    chk("rst_dout64", dout2, 0);
    rst = 1'b0;

    // Zero state: check cycle-accurate busy/done.
    @(negedge clk);
    din   = '0;
    mode  = 1'b0;
    start = 1'b1;
    exp_q.push_back('0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("busy_c%0d", c), busy, (c <= 5));
      chk($sformatf("done_c%0d", c), done, (c == 5));
    end

    // Single bit at x=1,y=0,z=0 -> bits 4 and 16.
    v_a = '0;
    v_a[4] = 1'b1;
    v_e = '0;
    v_e[4] = 1'b1;
    v_e[16] = 1'b1;
    run_job(v_a, 1'b0, v_e);
    chk("dout_hold", dout, v_e);

    run_job(v_ones, 1'b0, v_ones);
    run_job(v_pat, 1'b1, v_pat);

    // Start during busy is ignored: x=1,y=2,z=3 -> bits 47 and 59.
    v_a = '0;
    v_a[47] = 1'b1;
    v_e = '0;
    v_e[47] = 1'b1;
    v_e[59] = 1'b1;
    @(negedge clk);
    din   = v_a;
    mode  = 1'b0;
    start = 1'b1;
    exp_q.push_back(v_e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    din   = v_ones;
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored", busy, 1);
    repeat (4) @(negedge clk);

    // Reset mid-job aborts with no done pulse.
    @(negedge clk);
    din   = v_pat;
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dout", dout, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Start held high: back-to-back jobs with one IDLE gap.
    @(negedge clk);
    din   = v_pat;
    mode  = 1'b1;
    start = 1'b1;
    exp_q.push_back(v_pat);
    exp_q.push_back(v_pat);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 7) start = 1'b0;
      chk($sformatf("b2b_done_c%0d", c), done, (c == 5 || c == 11));
    end

`ifdef REVALUATE_ROUND_CONST_EN
    rc  = 4'b1010;
    v_e = '0;
    v_e[1] = 1'b1;
    v_e[3] = 1'b1;
    run_job('0, 1'b0, v_e);
    rc = '0;
`endif

    // 64-bit lanes, 8 slices per cycle: done 9 cycles after start.
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      for (int i = 0; i < 50; i++) din2[i*32 +: 32] = $urandom;
      mode2  = 1'b0;
      start2 = 1'b1;
      exp2_q.push_back(chi_ref(din2, 64, 1'b0, rc2));
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        start2 = 1'b0;
        chk($sformatf("done64_j%0d_c%0d", j, c), done2, (c == 9));
      end
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp2_q_drained", exp2_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/revaluate_slice_engine.md
Name: revaluate_slice_engine

Overview:
- Parametrised successor of the revaluate step: a controller/datapath pair that applies the non-linear chi step of the encoder permutation to a 5x5xLANE_W state.
- Work is done slice-serially: SLICES_PER_CYCLE z-slices per clock, under a counter-driven FSM.
- Adds a selectable pass-through mode and a busy flag.
- Sits between the preceding permutation step and the round controller, with the same start/done handshake as the other step blocks.

Parameters:
- LANE_W, 64, lane depth in bits. Legal values: 1, 2, 4, 8, 16, 32, 64.
- SLICES_PER_CYCLE, 1, slices processed per clock. Must divide LANE_W.
- Derived localparams:
  - NUM_CELLS = 25*LANE_W.
  - N_STEPS = LANE_W/SLICES_PER_CYCLE.
  - Counter width CW = max(1, clog2(N_STEPS)).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = chi, 1 = pass-through copy; latched with start
- data_in  input  NUM_CELLS  input state; latched with start
- busy  output  1  high from the cycle after start acceptance through the DONE cycle
- done  output  1  one-cycle pulse when data_out becomes valid
- data_out  output  NUM_CELLS  result state; held until the next accepted start
- round_const  input  LANE_W  present only with ROUND_CONST_EN

Behaviour:
- Bit mapping: bit a[x][y][z] is at index LANE_W*(5*y+x)+z, with x,y in 0..4 and z in 0..LANE_W-1.
- Chi: a'[x][y][z] = a[x][y][z] ^ (~a[(x+1)%5][y][z] & a[(x+2)%5][y][z]). Indices are mod 5 within the same row and slice. No carries; pure bitwise.
- Pass-through: a' = a.
- FSM states: IDLE, PROCESS, DONE.
  - IDLE: if start=1, latch data_in into the internal state register, latch mode, set cnt=0, go to PROCESS. Otherwise stay.
  - PROCESS: each cycle transform slices z = cnt*SLICES_PER_CYCLE .. +SLICES_PER_CYCLE-1 in place, then cnt++. When cnt = N_STEPS-1, transform the final slices and go to DONE.
  - DONE: copy the state register to data_out, assert done for exactly this cycle, go to IDLE.
- Slice independence: slices are transformed independently, so in-place update gives a correct result.
- Latency: start sampled at edge k gives done=1 during cycle k+N_STEPS+1. Example: 65 cycles for LANE_W=64, SLICES_PER_CYCLE=1.
- busy is high during PROCESS and DONE.
- start while busy: ignored, with no effect on latched data or mode.
- start held high continuously: a new job is accepted in the IDLE cycle after DONE, giving back-to-back jobs with a one-cycle IDLE gap.
- data_in and mode changes after acceptance: no effect on the current job.
- data_out changes only in DONE and stays stable otherwise.
- Reset values: busy=0, done=0, data_out=0, state register=0, cnt=0, FSM=IDLE.
- Reset mid-operation: abort immediately. No done pulse; the partial result is discarded.
- LANE_W=1 with SLICES_PER_CYCLE=1: N_STEPS=1, and PROCESS lasts one cycle.
- Illegal parameter combinations (SLICES_PER_CYCLE does not divide LANE_W) must fail elaboration via a generate-time error.

Optional Feature:
- Macro: REVALUATE_ROUND_CONST_EN.
- Defined:
  - The round_const port exists and is latched with start.
  - Lane (0,0) bits z get a'[0][0][z] ^= rc[z], applied in the same PROCESS cycle as that slice.
  - Applied after chi in chi mode; also applied in pass-through mode. This merges the iota step.
- Undefined: no port, no XOR, and the datapath is identical to the base behaviour.

Test Plan:
- Test config: LANE_W=4, SLICES_PER_CYCLE=1.
- All-zero data_in, mode=0, start pulse at cycle 0 -> busy=1 for cycles 1-5, done=1 only in cycle 5, data_out=0.
- data_in with only bit 4 set (x=1,y=0,z=0), mode=0 -> data_out has exactly bits 4 and 16 set.
- data_in all ones (100 bits), mode=0 -> data_out all ones. Repeat with mode=1 and a random pattern -> data_out equals data_in exactly.
- Start a job with pattern A; pulse start with pattern B at cycle 2 -> result equals chi(A), B ignored. Then rst at cycle 3 of a new job -> done never pulses, busy=0 and data_out=0 next cycle.
- With REVALUATE_ROUND_CONST_EN, round_const=4'b1010, zero data_in, mode=0 -> data_out bits 1 and 3 set, all others 0.
- LANE_W=64, SLICES_PER_CYCLE=8, random states -> matches the reference model; done exactly 9 cycles after start.
